display_module: RTL and testbench

- Drives a 4-digit, common-anode 7-segment display that shows eight 8-bit results: a 2x2 systolic-array result matrix (sa) and a 2x2 custom-datapath result matrix (custom).
- It cycles through the eight values, holding each for a fixed dwell time.
- For each value it shows the value's index on the leftmost digit and the unsigned decimal value on the other three digits.
- It sits at the top-level output stage, fed by the compute blocks and driving board pins.

---
 rtl/display_module.sv | 138 +++++++++++++
 tb/tb_display_module.sv | 122 ++++++++++++
 2 files changed

// File: rtl/display_module.sv
// Scans four 7-segment digits: leftmost shows which of eight 8-bit results is selected, the other three its decimal value.
// Segment and anode outputs are registered together, one cycle after the state they reflect.
module display_module #(
   parameter int REFRESH_BITS = 18,
   parameter int DWELL_CYCLES = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       display_rst,
   input  logic       display_en,
   input  logic [7:0] in_sa_11,
   input  logic [7:0] in_sa_12,
   input  logic [7:0] in_sa_21,
   input  logic [7:0] in_sa_22,
   input  logic [7:0] in_custom_11,
   input  logic [7:0] in_custom_12,
   input  logic [7:0] in_custom_21,
   input  logic [7:0] in_custom_22,
   output logic [3:0] anode_activate,
   output logic [6:0] out
);

   localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

   logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
   logic [DWELL_W-1:0]      dwell_q, dwell_d;
   logic [2:0]              idx_q, idx_d;
   logic [3:0]              anode_q, anode_d;
   logic [6:0]              seg_q, seg_d;

   logic [7:0]  val;
   logic [19:0] bcd_sh;
   logic [3:0]  hund, tens, ones;
   logic [1:0]  sel;
   logic [3:0]  digit;

   function automatic logic [6:0] seg_code(input logic [3:0] d);
      case (d)
         4'd0:    seg_code = 7'b0000001;
         4'd1:    seg_code = 7'b1001111;
         4'd2:    seg_code = 7'b0010010;
         4'd3:    seg_code = 7'b0000110;
         4'd4:    seg_code = 7'b1001100;
         4'd5:    seg_code = 7'b0100100;
         4'd6:    seg_code = 7'b0100000;
         4'd7:    seg_code = 7'b0001111;
         4'd8:    seg_code = 7'b0000000;
         4'd9:    seg_code = 7'b0000100;
         default: seg_code = 7'b1111111;
      endcase
   endfunction

   always_comb begin
      refresh_d = refresh_q;
      dwell_d   = dwell_q;
      idx_d     = idx_q;
      if (display_rst) begin
         refresh_d = '0;
         dwell_d   = '0;
         idx_d     = '0;
      end else if (display_en) begin
         refresh_d = refresh_q + REFRESH_BITS'(1);
         if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            idx_d   = idx_q + 3'd1;
         end else begin
            dwell_d = dwell_q + DWELL_W'(1);
         end
      end
   end

   // Inputs are muxed live so an updated result appears on the very next edge.
   always_comb begin
      case (idx_q)
         3'd0:    val = in_sa_11;
         3'd1:    val = in_sa_12;
         3'd2:    val = in_sa_21;
         3'd3:    val = in_sa_22;
         3'd4:    val = in_custom_11;
         3'd5:    val = in_custom_12;
         3'd6:    val = in_custom_21;
         default: val = in_custom_22;
      endcase
   end

   always_comb begin
      bcd_sh = {12'd0, val};
      for (int i = 0; i < 8; i++) begin
         if (bcd_sh[11:8] >= 4'd5)  bcd_sh[11:8]  = bcd_sh[11:8] + 4'd3;
         if (bcd_sh[15:12] >= 4'd5) bcd_sh[15:12] = bcd_sh[15:12] + 4'd3;
         if (bcd_sh[19:16] >= 4'd5) bcd_sh[19:16] = bcd_sh[19:16] + 4'd3;
         bcd_sh = bcd_sh << 1;
      end
      hund = bcd_sh[19:16];
      tens = bcd_sh[15:12];
      ones = bcd_sh[11:8];
   end

   assign sel = refresh_q[REFRESH_BITS-1 -: 2];

   always_comb begin
      anode_d = 4'b1111;
      seg_d   = 7'b1111111;
      digit   = ones;
      case (sel)
         2'd0:    begin anode_d = 4'b1110; digit = ones;          end
         2'd1:    begin anode_d = 4'b1101; digit = tens;          end
         2'd2:    begin anode_d = 4'b1011; digit = hund;          end
         default: begin anode_d = 4'b0111; digit = {1'b0, idx_q}; end
      endcase
      seg_d = seg_code(digit);
      if (display_rst || !display_en) begin
         anode_d = 4'b1111;
         seg_d   = 7'b1111111;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         refresh_q <= '0;
         dwell_q   <= '0;
         idx_q     <= '0;
         anode_q   <= 4'b1111;
         seg_q     <= 7'b1111111;
      end else begin
         refresh_q <= refresh_d;
         dwell_q   <= dwell_d;
         idx_q     <= idx_d;
         anode_q   <= anode_d;
         seg_q     <= seg_d;
      end
   end

   assign anode_activate = anode_q;
   assign out            = seg_q;

endmodule

// File: tb/tb_display_module.sv
// Directed bench for display_module with a short scan (4-bit refresh) and 64-cycle dwell.
module tb_display_module;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       display_rst = 1'b0;
   logic       display_en = 1'b1;
   logic [7:0] in_sa_11 = 8'd123, in_sa_12 = 8'd159, in_sa_21 = 8'd198, in_sa_22 = 8'd255;
   logic [7:0] in_custom_11 = 8'd123, in_custom_12 = 8'd159, in_custom_21 = 8'd198, in_custom_22 = 8'd255;
   logic [3:0] anode_activate;
   logic [6:0] out;

   int total = 0;
   int bad = 0;

   display_module #(.REFRESH_BITS(4), .DWELL_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .display_rst(display_rst), .display_en(display_en),
      .in_sa_11(in_sa_11), .in_sa_12(in_sa_12), .in_sa_21(in_sa_21), .in_sa_22(in_sa_22),
      .in_custom_11(in_custom_11), .in_custom_12(in_custom_12),
      .in_custom_21(in_custom_21), .in_custom_22(in_custom_22),
      .anode_activate(anode_activate), .out(out)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] seg7(input int d);
      case (d)
         0: seg7 = 7'b0000001;  1: seg7 = 7'b1001111;  2: seg7 = 7'b0010010;
         3: seg7 = 7'b0000110;  4: seg7 = 7'b1001100;  5: seg7 = 7'b0100100;
         6: seg7 = 7'b0100000;  7: seg7 = 7'b0001111;  8: seg7 = 7'b0000000;
         9: seg7 = 7'b0000100;  default: seg7 = 7'b1111111;
      endcase
   endfunction

   task automatic check(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
      total++;
      assert ({anode_activate, out} === {exp_an, exp_seg}) else begin
         bad++;
         $error("FAIL %s: anode=%b out=%b, expected anode=%b out=%b",
                tag, anode_activate, out, exp_an, exp_seg);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One full 16-cycle scan; the edge after entry shows refresh=0 of index idx.
   task automatic scan_check(input int idx, input int h, input int t, input int o);
      logic [3:0] an;
      int d;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         case (k / 4)
            0:       begin an = 4'b1110; d = o;   end
            1:       begin an = 4'b1101; d = t;   end
            2:       begin an = 4'b1011; d = h;   end
            default: begin an = 4'b0111; d = idx; end
         endcase
         check($sformatf("scan_i%0d_k%0d", idx, k), an, seg7(d));
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("reset_hold_%0d", i), 4'b1111, 7'b1111111);
      end

      rst = 1'b1;
      display_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("disabled_%0d", i), 4'b1111, 7'b1111111);
      end

      display_en = 1'b1;
      scan_check(0, 1, 2, 3);
      run(48);

      display_en = 1'b0;
      run(5);
      check("freeze_blank", 4'b1111, 7'b1111111);
      display_en = 1'b1;
      scan_check(1, 1, 5, 9);

      run(48 + 64);
      scan_check(3, 2, 5, 5);
      run(48 + 64);
      scan_check(5, 1, 5, 9);
      run(48 + 64 + 64);
      scan_check(0, 1, 2, 3);

      run(304 + 20);
      display_rst = 1'b1;
      @(negedge clk);
      check("display_rst_blank", 4'b1111, 7'b1111111);
      display_rst = 1'b0;
      in_sa_11 = 8'd7;
      scan_check(0, 0, 0, 7);

      run(6);
      #2 rst = 1'b0;
      #1 check("async_rst_blank", 4'b1111, 7'b1111111);
      display_rst = 1'b1;
      #1 rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("rst_release_drst_%0d", i), 4'b1111, 7'b1111111);
      end
      display_rst = 1'b0;
      @(negedge clk);
      check("after_drst_first", 4'b1110, seg7(7));
      run(3);
      @(negedge clk);
      check("after_drst_tens", 4'b1101, seg7(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
